// File: rtl/mfp_ahb_lite_master_arbiter_pkg.sv
// Shared encodings and small helpers for the two-master AHB-Lite arbiter.
package mfp_ahb_lite_master_arbiter_pkg;

  // Address-phase / data-phase owner encoding
  typedef enum logic {
    CPU_OWN = 1'b0,
    LDR_OWN = 1'b1
  } owner_e;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // True for any transfer that is not IDLE (BUSY is never issued by either master)
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans != HTRANS_IDLE);
  endfunction

  // Saturating 8-bit increment for the beat counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : (val + 8'h01);
  endfunction

endpackage

// File: rtl/mfp_ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter (CPU = master 0, SREC loader = master 1) in front
// of the bus matrix. Ownership moves only at IDLE, unlocked, HREADY=1 cycles so
// that the data phase straddling a switch is always an IDLE phase.
module mfp_ahb_lite_master_arbiter
  import mfp_ahb_lite_master_arbiter_pkg::*;
#(
  parameter int LDR_MAX_BEATS = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // CPU master
  input  logic [31:0] HADDR,
  input  logic [ 2:0] HBURST,
  input  logic        HMASTLOCK,
  input  logic [ 3:0] HPROT,
  input  logic [ 2:0] HSIZE,
  input  logic [ 1:0] HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  // Loader master
  input  logic [31:0] ldr_HADDR,
  input  logic [ 2:0] ldr_HBURST,
  input  logic        ldr_HMASTLOCK,
  input  logic [ 3:0] ldr_HPROT,
  input  logic [ 2:0] ldr_HSIZE,
  input  logic [ 1:0] ldr_HTRANS,
  input  logic [31:0] ldr_HWDATA,
  input  logic        ldr_HWRITE,
  output logic        ldr_HREADY,
  output logic        ldr_HRESP,
  input  logic        ldr_lock,
  // Slave side toward the matrix
  output logic [31:0] m_HADDR,
  output logic [ 2:0] m_HBURST,
  output logic        m_HMASTLOCK,
  output logic [ 3:0] m_HPROT,
  output logic [ 2:0] m_HSIZE,
  output logic [ 1:0] m_HTRANS,
  output logic [31:0] m_HWDATA,
  output logic        m_HWRITE,
  input  logic [31:0] m_HRDATA,
  input  logic        m_HREADY,
  input  logic        m_HRESP,
  output logic        owner
);

  localparam logic [7:0] MAX_BEATS = 8'(LDR_MAX_BEATS);

  owner_e     addr_owner_q;
  owner_e     data_owner_q;
  logic [7:0] beats_q;

  logic cpu_req_s;
  logic ldr_req_s;
  logic boundary_s;
  logic ldr_yield_s;

  assign owner = addr_owner_q;

  // Address/control mux by address owner, write data mux by data-phase owner
  always_comb begin
    m_HADDR     = HADDR;
    m_HBURST    = HBURST;
    m_HMASTLOCK = HMASTLOCK;
    m_HPROT     = HPROT;
    m_HSIZE     = HSIZE;
    m_HTRANS    = HTRANS;
    m_HWRITE    = HWRITE;
    if (addr_owner_q == LDR_OWN) begin
      m_HADDR     = ldr_HADDR;
      m_HBURST    = ldr_HBURST;
      m_HMASTLOCK = ldr_HMASTLOCK;
      m_HPROT     = ldr_HPROT;
      m_HSIZE     = ldr_HSIZE;
      m_HTRANS    = ldr_HTRANS;
      m_HWRITE    = ldr_HWRITE;
    end else begin
      m_HADDR     = HADDR;
    end
    m_HWDATA = (data_owner_q == LDR_OWN) ? ldr_HWDATA : HWDATA;
  end

  // Response steering: only the owner sees HREADY/HRESP, the other master stalls
  always_comb begin
    HRDATA     = m_HRDATA;
    HREADY     = 1'b0;
    HRESP      = 1'b0;
    ldr_HREADY = 1'b0;
    ldr_HRESP  = 1'b0;
    if (addr_owner_q == LDR_OWN) begin
      ldr_HREADY = m_HREADY;
      ldr_HRESP  = m_HRESP;
    end else begin
      HREADY = m_HREADY;
      HRESP  = m_HRESP;
    end
  end

  // Request and switch-point decode, evaluated on the muxed (owner's) controls
  always_comb begin
    cpu_req_s   = trans_active(HTRANS);
    ldr_req_s   = trans_active(ldr_HTRANS) | ldr_lock;
    boundary_s  = m_HREADY & ~trans_active(m_HTRANS) & ~m_HMASTLOCK;
    ldr_yield_s = ~ldr_lock & cpu_req_s & (~ldr_req_s | (beats_q >= MAX_BEATS));
  end

  // Ownership FSM, data-phase owner tracking and loader beat counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q <= CPU_OWN;
      data_owner_q <= CPU_OWN;
      beats_q      <= 8'd0;
    end else if (m_HREADY) begin
      data_owner_q <= addr_owner_q;
      case (addr_owner_q)
        CPU_OWN: begin
          if (boundary_s && ldr_req_s) begin
            addr_owner_q <= LDR_OWN;
            beats_q      <= 8'd0;
          end else begin
            addr_owner_q <= CPU_OWN;
          end
        end
        LDR_OWN: begin
          if (boundary_s && ldr_yield_s) begin
            addr_owner_q <= CPU_OWN;
          end else if (trans_active(m_HTRANS)) begin
            beats_q <= sat_inc8(beats_q);
          end else begin
            addr_owner_q <= LDR_OWN;
          end
        end
        default: begin
          addr_owner_q <= CPU_OWN;
        end
      endcase
    end else begin
      // Slave wait state: hold everything
      addr_owner_q <= addr_owner_q;
    end
  end

endmodule
